// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - Shared field layout, state encoding and helpers for the alarm sequencer
package alarm_pkg;

   // Counter width for ring, snooze-length and snooze-count counters
   localparam int CNT_W = 4;

   // Packed current-time bus field ranges
   localparam int MU_LSB  = 0;
   localparam int MU_MSB  = 3;
   localparam int MT_LSB  = 4;
   localparam int MT_MSB  = 6;
   localparam int HR_LSB  = 7;
   localparam int HR_MSB  = 11;
   localparam int DAY_LSB = 12;
   localparam int DAY_MSB = 14;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZING = 2'd3
   } state_t;

   // An alarm time is loadable only if every field is in its legal BCD/binary range
   function automatic logic time_valid(input logic [11:0] t);
      return (t[MU_MSB:MU_LSB] <= 4'd9) &&
             (t[MT_MSB:MT_LSB] <= 3'd5) &&
             (t[HR_MSB:HR_LSB] <= 5'd23);
   endfunction

endpackage

// File: rtl/alarm_controller_minute_tick_gen.sv
// rtl/alarm_controller_minute_tick_gen.sv - Minute tick from natural current-time changes only
module minute_tick_gen
   import alarm_pkg::*;
(
   input  logic        Clk,
   input  logic        Clr,
   input  logic [14:0] CTO,
   input  logic        LD_CT,
   output logic        tick
);

   logic [14:0] cto_q;
   logic        ld_q;

   // Remember last cycle's time and load strobe; ld_q masks the change that
   // lands one cycle after a load when the time module registers it
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         cto_q <= '0;
         ld_q  <= 1'b0;
      end else begin
         cto_q <= CTO;
         ld_q  <= LD_CT;
      end
   end

   assign tick = (CTO != cto_q) && !LD_CT && !ld_q;

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - Alarm ring/snooze/auto-off sequencer; optional SNOOZE_LIMIT_EN caps snoozes per event
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 9,
   parameter int RING_TIMEOUT_MIN = 5,
   parameter int MAX_SNOOZE       = 3
)
(
   input  logic        Clk,
   input  logic        Clr,
   input  logic [14:0] CTO,
   input  logic        LD_CT,
   input  logic [11:0] ATI,
   input  logic [6:0]  DMI,
   input  logic        LD_AT,
   input  logic        ALARM_EN,
   input  logic        SNOOZE,
   input  logic        STOP,
   output logic [11:0] ATO,
   output logic [6:0]  DMO,
   output logic        BUZZ,
   output logic        SNOOZED,
   output logic        LD_ERR
);

   localparam logic [CNT_W-1:0] SNZ_INIT = SNOOZE_MIN[CNT_W-1:0];
   localparam logic [CNT_W-1:0] RING_TO  = RING_TIMEOUT_MIN[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic             tick;
   logic             match;
   logic             ld_ok;
   logic             snooze_ok;
   logic [7:0]       day_mask;
   logic [CNT_W-1:0] ring_cnt;
   logic [CNT_W-1:0] snz_left;
   logic [CNT_W-1:0] ring_inc;
   logic [CNT_W-1:0] snz_dec;

   minute_tick_gen u_tick (
      .Clk   (Clk),
      .Clr   (Clr),
      .CTO   (CTO),
      .LD_CT (LD_CT),
      .tick  (tick)
   );

   // Day 7 maps onto the padded zero bit so it can never match
   assign day_mask  = {1'b0, DMO};
   assign match     = (CTO[HR_MSB:MU_LSB] == ATO) && day_mask[CTO[DAY_MSB:DAY_LSB]];
   assign ld_ok     = LD_AT && time_valid(ATI);
   assign ring_inc  = (ring_cnt == '1) ? ring_cnt : ring_cnt + CNT_ONE;
   assign snz_dec   = (snz_left == '0) ? snz_left : snz_left - CNT_ONE;

`ifdef SNOOZE_LIMIT_EN
   logic [CNT_W-1:0] snooze_cnt;
   localparam logic [CNT_W-1:0] MAX_SNZ = MAX_SNOOZE[CNT_W-1:0];
   assign snooze_ok = (snooze_cnt < MAX_SNZ);

   // Snoozes taken in the current alarm event, cleared when a new ring starts
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         snooze_cnt <= '0;
      end else if (ALARM_EN && !ld_ok) begin
         if (state == ARMED && tick && match)
            snooze_cnt <= '0;
         else if (state == RINGING && !STOP && SNOOZE && snooze_ok && snooze_cnt != '1)
            snooze_cnt <= snooze_cnt + CNT_ONE;
      end
   end
`else
   assign snooze_ok = 1'b1;
`endif

   // Alarm time/day mask storage with load validation
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         ATO    <= '0;
         DMO    <= 7'h7F;
         LD_ERR <= 1'b0;
      end else begin
         LD_ERR <= LD_AT && !time_valid(ATI);
         if (ld_ok) begin
            ATO <= ATI;
            DMO <= DMI;
         end
      end
   end

   // Sequencer FSM; BUZZ/SNOOZED are registered alongside the state they reflect
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state    <= IDLE;
         BUZZ     <= 1'b0;
         SNOOZED  <= 1'b0;
         ring_cnt <= '0;
         snz_left <= '0;
      end else if (!ALARM_EN) begin
         state   <= IDLE;
         BUZZ    <= 1'b0;
         SNOOZED <= 1'b0;
      end else if (ld_ok) begin
         state   <= ARMED;
         BUZZ    <= 1'b0;
         SNOOZED <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= ARMED;
            end
            ARMED: begin
               if (tick && match) begin
                  state    <= RINGING;
                  BUZZ     <= 1'b1;
                  ring_cnt <= '0;
               end
            end
            RINGING: begin
               if (STOP) begin
                  state <= ARMED;
                  BUZZ  <= 1'b0;
               end else if (SNOOZE && snooze_ok) begin
                  state    <= SNOOZING;
                  BUZZ     <= 1'b0;
                  SNOOZED  <= 1'b1;
                  snz_left <= SNZ_INIT;
               end else if (tick) begin
                  ring_cnt <= ring_inc;
                  if (ring_inc == RING_TO) begin
                     state <= ARMED;
                     BUZZ  <= 1'b0;
                  end
               end
            end
            SNOOZING: begin
               if (STOP) begin
                  state   <= ARMED;
                  SNOOZED <= 1'b0;
               end else if (tick) begin
                  snz_left <= snz_dec;
                  if (snz_dec == '0) begin
                     state    <= RINGING;
                     BUZZ     <= 1'b1;
                     SNOOZED  <= 1'b0;
                     ring_cnt <= '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - Directed table-driven bench for alarm_controller
module tb_alarm_controller;

   logic        Clk = 1'b0;
   logic        Clr;
   logic [14:0] CTO;
   logic        LD_CT;
   logic [11:0] ATI;
   logic [6:0]  DMI;
   logic        LD_AT;
   logic        ALARM_EN;
   logic        SNOOZE;
   logic        STOP;
   logic [11:0] ATO;
   logic [6:0]  DMO;
   logic        BUZZ;
   logic        SNOOZED;
   logic        LD_ERR;

   int checks   = 0;
   int failures = 0;

   alarm_controller dut (
      .Clk      (Clk),
      .Clr      (Clr),
      .CTO      (CTO),
      .LD_CT    (LD_CT),
      .ATI      (ATI),
      .DMI      (DMI),
      .LD_AT    (LD_AT),
      .ALARM_EN (ALARM_EN),
      .SNOOZE   (SNOOZE),
      .STOP     (STOP),
      .ATO      (ATO),
      .DMO      (DMO),
      .BUZZ     (BUZZ),
      .SNOOZED  (SNOOZED),
      .LD_ERR   (LD_ERR)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [14:0] cto;
      logic        ld_ct;
      logic        ld_at;
      logic [11:0] ati;
      logic [6:0]  dmi;
      logic        en;
      logic        snz;
      logic        stp;
      logic        buzz;
      logic        snoozed;
      logic        ld_err;
      logic [11:0] ato;
      logic [6:0]  dmo;
   } vec_t;

   vec_t tbl[17];

   function automatic logic [11:0] mk12(input int h, input int m);
      return {5'(h), 3'(m / 10), 4'(m % 10)};
   endfunction

   function automatic logic [14:0] mk(input int d, input int h, input int m);
      return {3'(d), mk12(h, m)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge Clk);
   endtask

   task automatic tick_to(input int m);
      CTO = mk(1, 7, m);
      cyc();
   endtask

   task automatic ring_up(input string nm);
      CTO   = mk(1, 7, 29);
      LD_CT = 1'b1;
      cyc();
      LD_CT = 1'b0;
      cyc();
      CTO = mk(1, 7, 30);
      cyc();
      chk({nm, "_ring_buzz"}, BUZZ, 1'b1);
   endtask

   initial begin
      logic [11:0] a;
      a = mk12(7, 30);
      //         cto          ldct ldat ati                    dmi    en snz stp  buzz snzd err ato dmo
      tbl[0]  = '{mk(1,7,28), 0, 1, a,                       7'h02, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[1]  = '{mk(1,7,29), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[2]  = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   1, 0, 0, a, 7'h02};
      tbl[3]  = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 1,   0, 0, 0, a, 7'h02};
      tbl[4]  = '{mk(2,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[5]  = '{mk(2,7,31), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[6]  = '{mk(2,7,31), 1, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[7]  = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[8]  = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[9]  = '{mk(1,7,29), 1, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[10] = '{mk(1,7,29), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[11] = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   1, 0, 0, a, 7'h02};
      tbl[12] = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 1, 1,   0, 0, 0, a, 7'h02};
      tbl[13] = '{mk(1,7,30), 0, 1, {5'd24, 3'd0, 4'd0},     7'h7F, 1, 0, 0,   0, 0, 1, a, 7'h02};
      tbl[14] = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};
      tbl[15] = '{mk(1,7,30), 0, 1, {5'd7, 3'd3, 4'd10},     7'h7F, 1, 0, 0,   0, 0, 1, a, 7'h02};
      tbl[16] = '{mk(1,7,30), 0, 0, 12'h0,                   7'h00, 1, 0, 0,   0, 0, 0, a, 7'h02};

      Clr = 1'b1; CTO = '0; LD_CT = 0; ATI = '0; DMI = '0; LD_AT = 0;
      ALARM_EN = 0; SNOOZE = 0; STOP = 0;
      cyc(); cyc();
      Clr = 1'b0;
      cyc();
      chk("rst_ato", ATO, 12'h0);
      chk("rst_dmo", DMO, 7'h7F);
      chk("rst_buzz", BUZZ, 1'b0);
      chk("rst_snoozed", SNOOZED, 1'b0);
      chk("rst_ld_err", LD_ERR, 1'b0);

      for (int i = 0; i < 17; i++) begin
         CTO = tbl[i].cto; LD_CT = tbl[i].ld_ct; LD_AT = tbl[i].ld_at;
         ATI = tbl[i].ati; DMI = tbl[i].dmi; ALARM_EN = tbl[i].en;
         SNOOZE = tbl[i].snz; STOP = tbl[i].stp;
         cyc();
         chk($sformatf("row%0d_buzz", i), BUZZ, tbl[i].buzz);
         chk($sformatf("row%0d_snoozed", i), SNOOZED, tbl[i].snoozed);
         chk($sformatf("row%0d_ld_err", i), LD_ERR, tbl[i].ld_err);
         chk($sformatf("row%0d_ato", i), ATO, tbl[i].ato);
         chk($sformatf("row%0d_dmo", i), DMO, tbl[i].dmo);
      end
      LD_CT = 0; LD_AT = 0; SNOOZE = 0; STOP = 0;

      // Snooze for 9 ticks, ring again, then auto-off after 5 ticks
      ring_up("snz");
      SNOOZE = 1; cyc(); SNOOZE = 0;
      chk("snz_buzz_off", BUZZ, 1'b0);
      chk("snz_snoozed_on", SNOOZED, 1'b1);
      for (int i = 1; i <= 9; i++) begin
         tick_to(30 + i);
         if (i == 8) begin
            chk("snz_tick8_buzz", BUZZ, 1'b0);
            chk("snz_tick8_snoozed", SNOOZED, 1'b1);
         end
      end
      chk("snz_tick9_buzz", BUZZ, 1'b1);
      chk("snz_tick9_snoozed", SNOOZED, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick_to(39 + i);
         if (i == 4) chk("to_tick4_buzz", BUZZ, 1'b1);
      end
      chk("to_tick5_buzz", BUZZ, 1'b0);
      chk("to_tick5_snoozed", SNOOZED, 1'b0);

      // Alarm switched off while snoozing never rings again
      ring_up("dis");
      SNOOZE = 1; cyc(); SNOOZE = 0;
      ALARM_EN = 0; cyc();
      chk("dis_snoozed", SNOOZED, 1'b0);
      chk("dis_buzz", BUZZ, 1'b0);
      for (int i = 1; i <= 9; i++) tick_to(30 + i);
      chk("dis_after_snooze_buzz", BUZZ, 1'b0);
      CTO = mk(1, 7, 29); LD_CT = 1; cyc(); LD_CT = 0; cyc();
      tick_to(30);
      chk("dis_match_buzz", BUZZ, 1'b0);
      ALARM_EN = 1; cyc();

      // Three full snoozes, then a fourth request
      ring_up("lim");
      for (int k = 0; k < 3; k++) begin
         SNOOZE = 1; cyc(); SNOOZE = 0;
         for (int i = 1; i <= 9; i++) tick_to(30 + 9 * k + i);
         chk($sformatf("lim_round%0d_buzz", k), BUZZ, 1'b1);
      end
      SNOOZE = 1; cyc(); SNOOZE = 0;
`ifdef SNOOZE_LIMIT_EN
      chk("lim_4th_buzz", BUZZ, 1'b1);
      chk("lim_4th_snoozed", SNOOZED, 1'b0);
`else
      chk("lim_4th_buzz", BUZZ, 1'b0);
      chk("lim_4th_snoozed", SNOOZED, 1'b1);
`endif
      STOP = 1; cyc(); STOP = 0;
      chk("lim_stop_buzz", BUZZ, 1'b0);
      chk("lim_stop_snoozed", SNOOZED, 1'b0);

      // Asynchronous clear in the middle of ringing
      ring_up("clr");
      Clr = 1'b1;
      #1;
      chk("clr_buzz", BUZZ, 1'b0);
      chk("clr_ato", ATO, 12'h0);
      chk("clr_dmo", DMO, 7'h7F);
      chk("clr_snoozed", SNOOZED, 1'b0);
      cyc();
      Clr = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
